mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store path (MEM). It serialises each granted access into 1, 2 or 4 byte cycles, assembles or disassembles little-endian words, and raises per-requester stall requests to STALLER while an access is pending. It sits between the IF/MEM stages and the RAM. It consumes the address that EX produces in `alurslt_EXMEM_o` for loads and stores.

## Interface
Parameters:
- none (RAM is fixed 8-bit data, 32-bit address)

Ports:
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  asynchronous, active-low reset
- if_req_i  in  1  IF requests a 4-byte instruction read; level, held until `if_done_o`
- if_addr_i  in  32  IF word address
- mem_req_i  in  1  MEM requests an access; level, held until `mem_done_o`
- mem_we_i  in  1  1 = store, 0 = load
- mem_len_i  in  2  size: 00 = byte, 01 = half, 10 or 11 = word
- mem_addr_i  in  32  MEM byte address
- mem_wdata_i  in  32  store data; byte k is bits [8k+7:8k]
- ram_din_i  in  8  RAM read data, valid one cycle after its address
- ram_addr_o  out  32  RAM byte address (registered)
- ram_wr_o  out  1  RAM write strobe (registered)
- ram_dout_o  out  8  RAM write data (registered)
- if_done_o  out  1  one-cycle pulse: IF read complete
- if_rdata_o  out  32  fetched word, valid while `if_done_o`
- mem_done_o  out  1  one-cycle pulse: MEM access complete
- mem_rdata_o  out  32  load data, zero-extended above the access size, valid while `mem_done_o`
- rq_STALLER_o  out  2  [1] = `mem_req_i & ~mem_done_o`; [0] = `if_req_i & ~if_done_o` (combinational)

## Operation
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - If `mem_req_i` is set, grant MEM. Priority is MEM over IF.
  - Otherwise, if `if_req_i` is set, grant IF.
  - On grant, latch owner, address, we, byte count n (1/2/4, IF always 4) and wdata, then go to ISSUE with cnt = 0.
  - Inputs need not be held stable after the grant cycle.
- ISSUE (cnt = 0..n-1):
  - Drive `ram_addr_o = base + cnt`.
  - For a store, drive `ram_wr_o = 1` and `ram_dout_o = wdata[8cnt+7:8cnt]`.
  - For a read, drive `ram_wr_o = 0`. The byte for address cnt is captured into rdata[8cnt+7:8cnt] on the following edge.
  - When cnt = n-1: a store goes to DONE; a read goes to DRAIN.
- DRAIN (reads only): capture the last byte, then go to DONE.
- DONE:
  - Pulse the owner's done output for one cycle with the assembled data.
  - Unused upper bytes of rdata are 0.
  - Go to IDLE.
- Outside ISSUE: `ram_wr_o = 0`, `ram_addr_o = 0`, `ram_dout_o = 0`.
- Address arithmetic is 32-bit and wraps modulo 2^32. There is no alignment check; misaligned accesses are performed byte-wise as given.
- Requesters must deassert req in the cycle they observe done, or the next IDLE cycle re-grants them.
- If req drops mid-access, the access still completes and done still pulses.
- Reset (asynchronous, any state, including mid-access):
  - State IDLE, cnt 0.
  - All outputs 0, including data registers.
  - The in-flight access is aborted. Partially written bytes remain in RAM.

## Timing
- Let T be the IDLE cycle in which req is sampled high.
- Store of n bytes:
  - Byte k is written in cycle T+1+k.
  - done is asserted in T+1+n: word T+5, half T+3, byte T+2.
- Read of n bytes:
  - Address k is presented in T+1+k.
  - The byte arrives on `ram_din_i` in T+2+k.
  - done is asserted in T+2+n: word/fetch T+6, half T+4, byte T+3.
- The earliest next grant is the IDLE cycle immediately after done. A back-to-back word fetch therefore takes 7 cycles per fetch.
- Simultaneous IF and MEM requests in IDLE: MEM is served first. IF is granted in the first IDLE cycle after `mem_done_o` and is held off by `rq_STALLER_o[0]` meanwhile.
- A request arriving during ISSUE/DRAIN/DONE waits for IDLE. There is no preemption.
- `rq_STALLER_o` is high from the cycle req rises through the cycle before done, and low in the done cycle.

## Test plan
- **IF word fetch.** Stimulus: RAM holds 0x13,0x05,0x10,0x00 at 0x100; `if_req_i` set at T with `if_addr_i` = 0x100. Required: addresses 0x100..0x103 in T+1..T+4; `if_done_o` pulse at T+6 with `if_rdata_o` = 0x00100513; `rq_STALLER_o` = 01 during T..T+5.
- **Store half then load byte.**
  - Stimulus: store with `mem_addr_i` = 0x20, `mem_wdata_i` = 0xDEADBEEF, `mem_len_i` = 01. Required: writes 0xEF at 0x20 (T+1) and 0xBE at 0x21 (T+2); done at T+3.
  - Stimulus: then a byte load at 0x21. Required: `mem_rdata_o` = 0x000000BE.
- **Simultaneous requests.** Stimulus: `if_req_i` and `mem_req_i` both high in the same IDLE cycle, MEM a word load. Required: MEM done at T+6; IF granted at T+7 with done at T+13; `rq_STALLER_o[0]` high throughout T..T+12.
- **Address wrap.** Stimulus: word load at 0xFFFFFFFE. Required: addresses 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1 in order.
- **Reset mid-access.** Stimulus: `rst_n` pulled low asynchronously during the second write byte of a word store. Required: `ram_wr_o`, both done outputs and `rq_STALLER_o` are 0 immediately; after release with no req, the block stays IDLE; a new request is served with normal latency.
- **Request dropped mid-access.** Stimulus: `mem_req_i` deasserted during ISSUE. Required: the access completes, `mem_done_o` pulses once, and no re-grant follows.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundles the IF/MEM request handshakes and the byte-wide RAM port that
// mem_port_arbiter serialises onto.
interface mem_port_arbiter_if;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [1:0]  mem_len_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [7:0]  ram_din_i;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o;
  logic [7:0]  ram_dout_o;
  logic        if_done_o;
  logic [31:0] if_rdata_o;
  logic        mem_done_o;
  logic [31:0] mem_rdata_o;
  logic [1:0]  rq_STALLER_o;

  // Arbiter side
  modport slave (
    input  if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i,
           mem_addr_i, mem_wdata_i, ram_din_i,
    output ram_addr_o, ram_wr_o, ram_dout_o, if_done_o, if_rdata_o,
           mem_done_o, mem_rdata_o, rq_STALLER_o
  );

  // Requester / RAM side
  modport master (
    output if_req_i, if_addr_i, mem_req_i, mem_we_i, mem_len_i,
           mem_addr_i, mem_wdata_i, ram_din_i,
    input  ram_addr_o, ram_wr_o, ram_dout_o, if_done_o, if_rdata_o,
           mem_done_o, mem_rdata_o, rq_STALLER_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and load/store.
// Each granted access is split into 1, 2 or 4 byte cycles; read bytes are
// assembled little-endian and the owner gets a one-cycle done pulse.
module mem_port_arbiter (
  input  logic              clk,
  input  logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [1:0]  last_cnt;
  logic        owner_mem;
  logic        we;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [31:0] rdata;

  logic        grant_we;
  logic [31:0] grant_addr;
  logic [1:0]  grant_last;
  logic        cap_en;
  logic [1:0]  cap_idx;
  logic [31:0] rdata_merged;
  logic [31:0] addr_next;
  logic [7:0]  byte_next;
  logic [1:0]  cnt_next;

  // Stall requests are held low while reset is asserted so nothing downstream stalls on a dead port
  assign bus.rq_STALLER_o = {bus.mem_req_i & ~bus.mem_done_o,
                             bus.if_req_i  & ~bus.if_done_o} & {2{rst_n}};

  // Grant decode (MEM wins) and the next-byte / read-assembly helpers
  always_comb begin
    grant_we   = bus.mem_req_i & bus.mem_we_i;
    grant_addr = bus.mem_req_i ? bus.mem_addr_i : bus.if_addr_i;
    grant_last = 2'd3;
    if (bus.mem_req_i) begin
      case (bus.mem_len_i)
        2'b00:   grant_last = 2'd0;
        2'b01:   grant_last = 2'd1;
        default: grant_last = 2'd3;
      endcase
    end

    cnt_next  = cnt + 2'd1;
    addr_next = base + {30'd0, cnt_next};
    byte_next = wdata[{cnt_next, 3'b000} +: 8];

    cap_en  = ((state == ISSUE) && (cnt != 2'd0) && !we) || (state == DRAIN);
    cap_idx = (state == DRAIN) ? last_cnt : (cnt - 2'd1);
    rdata_merged = rdata;
    rdata_merged[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
  end

  // Main sequencer: grant, issue bytes, drain the last read byte, pulse done
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= 2'd0;
      last_cnt        <= 2'd0;
      owner_mem       <= 1'b0;
      we              <= 1'b0;
      base            <= 32'd0;
      wdata           <= 32'd0;
      rdata           <= 32'd0;
      bus.ram_addr_o  <= 32'd0;
      bus.ram_wr_o    <= 1'b0;
      bus.ram_dout_o  <= 8'd0;
      bus.if_done_o   <= 1'b0;
      bus.if_rdata_o  <= 32'd0;
      bus.mem_done_o  <= 1'b0;
      bus.mem_rdata_o <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.mem_req_i || bus.if_req_i) begin
            owner_mem      <= bus.mem_req_i;
            we             <= grant_we;
            base           <= grant_addr;
            wdata          <= bus.mem_req_i ? bus.mem_wdata_i : 32'd0;
            last_cnt       <= grant_last;
            cnt            <= 2'd0;
            rdata          <= 32'd0;
            bus.ram_addr_o <= grant_addr;
            bus.ram_wr_o   <= grant_we;
            bus.ram_dout_o <= grant_we ? bus.mem_wdata_i[7:0] : 8'd0;
            state          <= ISSUE;
          end
        end

        ISSUE: begin
          if (cap_en)
            rdata <= rdata_merged;
          if (cnt == last_cnt) begin
            cnt            <= 2'd0;
            bus.ram_addr_o <= 32'd0;
            bus.ram_wr_o   <= 1'b0;
            bus.ram_dout_o <= 8'd0;
            if (we) begin
              bus.mem_done_o  <= 1'b1;
              bus.mem_rdata_o <= 32'd0;
              state           <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else begin
            cnt            <= cnt_next;
            bus.ram_addr_o <= addr_next;
            bus.ram_dout_o <= we ? byte_next : 8'd0;
          end
        end

        DRAIN: begin
          rdata <= rdata_merged;
          if (owner_mem) begin
            bus.mem_done_o  <= 1'b1;
            bus.mem_rdata_o <= rdata_merged;
          end else begin
            bus.if_done_o  <= 1'b1;
            bus.if_rdata_o <= rdata_merged;
          end
          state <= DONE;
        end

        DONE: begin
          bus.if_done_o   <= 1'b0;
          bus.if_rdata_o  <= 32'd0;
          bus.mem_done_o  <= 1'b0;
          bus.mem_rdata_o <= 32'd0;
          state           <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a byte RAM model, directed
// vector table, hand-written corner sequences and random transactions
// checked against a transaction-level reference memory.
module tb_mem_port_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model and transaction-level reference contents
  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  // Byte RAM: write on strobe, read data one cycle after the address
  always @(posedge clk) begin
    if (bus.ram_wr_o)
      ram[bus.ram_addr_o] = bus.ram_dout_o;
    bus.ram_din_i <= ram.exists(bus.ram_addr_o) ? ram[bus.ram_addr_o] : 8'h00;
  end

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  task automatic preload(input logic [31:0] a, input logic [7:0] d);
    ram[a]     = d;
    ref_mem[a] = d;
  endtask

  function automatic logic [7:0] refByte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Reference: bytes moved and latency from the transaction rules
  task automatic modelTxn(input bit is_mem, input bit we, input logic [1:0] len,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output int lat);
    int n;
    n  = !is_mem ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
    rd = 32'd0;
    for (int i = 0; i < n; i++) begin
      if (is_mem && we) ref_mem[addr + i] = wdata[8*i +: 8];
      else              rd[8*i +: 8]      = refByte(addr + i);
    end
    lat = (is_mem && we) ? n + 1 : n + 2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Run one transaction from an IDLE cycle; trace_ok covers the per-cycle RAM port and stall behaviour
  task automatic applyStimulus(input bit is_mem, input bit we, input logic [1:0] len,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               output logic [31:0] got, output int lat, output bit trace_ok);
    int n;
    bit done_now, other_done, stall_bit;
    n        = !is_mem ? 4 : (len == 2'b00 ? 1 : (len == 2'b01 ? 2 : 4));
    got      = 32'hxxxxxxxx;
    lat      = -1;
    trace_ok = 1'b1;
    @(negedge clk);
    if (is_mem) begin
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_len_i   = len;
      bus.mem_addr_i  = addr;
      bus.mem_wdata_i = wdata;
    end else begin
      bus.if_req_i  = 1'b1;
      bus.if_addr_i = addr;
    end
    #1;
    if (bus.rq_STALLER_o !== (is_mem ? 2'b10 : 2'b01)) trace_ok = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      done_now   = is_mem ? bus.mem_done_o : bus.if_done_o;
      other_done = is_mem ? bus.if_done_o  : bus.mem_done_o;
      stall_bit  = is_mem ? bus.rq_STALLER_o[1] : bus.rq_STALLER_o[0];
      if (other_done) trace_ok = 1'b0;
      if (k <= n) begin
        if (bus.ram_addr_o !== addr + k - 1) trace_ok = 1'b0;
        if (bus.ram_wr_o !== (is_mem && we)) trace_ok = 1'b0;
        if ((is_mem && we) && bus.ram_dout_o !== wdata[8*(k-1) +: 8]) trace_ok = 1'b0;
      end else if (bus.ram_wr_o !== 1'b0 || bus.ram_addr_o !== 32'd0) begin
        trace_ok = 1'b0;
      end
      if (done_now) begin
        lat = k;
        got = is_mem ? bus.mem_rdata_o : bus.if_rdata_o;
        if (stall_bit !== 1'b0) trace_ok = 1'b0;
        bus.mem_req_i = 1'b0;
        bus.if_req_i  = 1'b0;
        break;
      end else if (stall_bit !== 1'b1) begin
        trace_ok = 1'b0;
      end
    end
    bus.mem_req_i = 1'b0;
    bus.if_req_i  = 1'b0;
  endtask

  logic [31:0] got, exp_rd;
  int          lat, exp_lat, mem_k, if_k, done_cnt;
  bit          ok, ok2;
  logic [31:0] if_got, mem_got;

  initial begin
    clk             = 1'b0;
    rst_n           = 1'b0;
    checks          = 0;
    errors          = 0;
    bus.if_req_i    = 1'b0;
    bus.if_addr_i   = 32'd0;
    bus.mem_req_i   = 1'b0;
    bus.mem_we_i    = 1'b0;
    bus.mem_len_i   = 2'b00;
    bus.mem_addr_i  = 32'd0;
    bus.mem_wdata_i = 32'd0;
    bus.ram_din_i   = 8'd0;

    preload(32'h100, 8'h13); preload(32'h101, 8'h05);
    preload(32'h102, 8'h10); preload(32'h103, 8'h00);
    preload(32'hFFFFFFFE, 8'h11); preload(32'hFFFFFFFF, 8'h22);
    preload(32'h0, 8'h33); preload(32'h1, 8'h44);

    //            is_mem we  len    addr           wdata          exp_rdata      lat
    vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h00000100, 32'h0,        32'h00100513, 6};
    vecs[1]  = '{1'b1, 1'b1, 2'b01, 32'h00000020, 32'hDEADBEEF, 32'h00000000, 3};
    vecs[2]  = '{1'b1, 1'b0, 2'b00, 32'h00000021, 32'h0,        32'h000000BE, 3};
    vecs[3]  = '{1'b1, 1'b0, 2'b01, 32'h00000020, 32'h0,        32'h0000BEEF, 4};
    vecs[4]  = '{1'b1, 1'b1, 2'b10, 32'h00000030, 32'h12345678, 32'h00000000, 5};
    vecs[5]  = '{1'b1, 1'b0, 2'b10, 32'h00000030, 32'h0,        32'h12345678, 6};
    vecs[6]  = '{1'b1, 1'b1, 2'b00, 32'h00000033, 32'hAAAAAA9C, 32'h00000000, 2};
    vecs[7]  = '{1'b1, 1'b0, 2'b10, 32'h00000030, 32'h0,        32'h9C345678, 6};
    vecs[8]  = '{1'b1, 1'b0, 2'b10, 32'hFFFFFFFE, 32'h0,        32'h44332211, 6};
    vecs[9]  = '{1'b1, 1'b1, 2'b11, 32'h00000050, 32'hCAFEF00D, 32'h00000000, 5};
    vecs[10] = '{1'b1, 1'b0, 2'b11, 32'h00000051, 32'h0,        32'h00CAFEF0, 6};

    // Reset state, including stall suppression with a request pending
    repeat (3) @(negedge clk);
    bus.if_req_i = 1'b1;
    #1;
    checkOutput("reset_stall", {30'd0, bus.rq_STALLER_o}, 32'd0);
    checkOutput("reset_ram", {bus.ram_wr_o, bus.ram_dout_o, 23'd0}, 32'd0);
    checkOutput("reset_addr", bus.ram_addr_o, 32'd0);
    checkOutput("reset_done", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    checkOutput("reset_rdata", bus.if_rdata_o | bus.mem_rdata_o, 32'd0);
    bus.if_req_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    foreach (vecs[i]) begin
      modelTxn(vecs[i].is_mem, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, exp_rd, exp_lat);
      applyStimulus(vecs[i].is_mem, vecs[i].we, vecs[i].len, vecs[i].addr, vecs[i].wdata, got, lat, ok);
      checkOutput($sformatf("vec%0d_rdata", i), got, vecs[i].exp_rdata);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      checkOutput($sformatf("vec%0d_trace", i), {31'd0, ok}, 32'd1);
    end

    // Simultaneous IF and MEM requests: MEM first, IF stalled until granted
    @(negedge clk);
    bus.mem_req_i  = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b10; bus.mem_addr_i = 32'h30;
    bus.if_req_i   = 1'b1; bus.if_addr_i = 32'h100;
    mem_k = -1; if_k = -1; ok = 1'b1;
    #1;
    if (bus.rq_STALLER_o !== 2'b11) ok = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.mem_done_o && mem_k < 0) begin mem_k = k; mem_got = bus.mem_rdata_o; bus.mem_req_i = 1'b0; end
      if (bus.if_done_o && if_k < 0) begin if_k = k; if_got = bus.if_rdata_o; bus.if_req_i = 1'b0; end
      if (k <= 12 && bus.rq_STALLER_o[0] !== 1'b1) ok = 1'b0;
      if (if_k >= 0) begin
        if (bus.rq_STALLER_o[0] !== 1'b0) ok = 1'b0;
        break;
      end
    end
    bus.mem_req_i = 1'b0; bus.if_req_i = 1'b0;
    checkOutput("simul_mem_done_cycle", mem_k, 6);
    checkOutput("simul_if_done_cycle", if_k, 13);
    checkOutput("simul_mem_rdata", mem_got, 32'h9C345678);
    checkOutput("simul_if_rdata", if_got, 32'h00100513);
    checkOutput("simul_if_stall", {31'd0, ok}, 32'd1);

    // Request dropped mid-access: completes once, no re-grant
    @(negedge clk);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_len_i = 2'b10; bus.mem_addr_i = 32'h50;
    mem_k = -1; done_cnt = 0; ok = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 2) bus.mem_req_i = 1'b0;
      if (bus.mem_done_o) begin
        done_cnt++;
        if (mem_k < 0) begin mem_k = k; mem_got = bus.mem_rdata_o; end
      end
      if (k > 6 && (bus.ram_addr_o !== 32'd0 || bus.ram_wr_o !== 1'b0)) ok = 1'b0;
    end
    checkOutput("drop_done_cycle", mem_k, 6);
    checkOutput("drop_done_count", done_cnt, 1);
    checkOutput("drop_rdata", mem_got, 32'hCAFEF00D);
    checkOutput("drop_no_regrant", {31'd0, ok}, 32'd1);

    // Reset asserted during the second write byte of a word store
    @(negedge clk);
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_len_i = 2'b10;
    bus.mem_addr_i = 32'h40; bus.mem_wdata_i = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rstmid_second_byte_addr", bus.ram_addr_o, 32'h41);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rstmid_wr", {31'd0, bus.ram_wr_o}, 32'd0);
    checkOutput("rstmid_done", {30'd0, bus.if_done_o, bus.mem_done_o}, 32'd0);
    checkOutput("rstmid_stall", {30'd0, bus.rq_STALLER_o}, 32'd0);
    bus.mem_req_i = 1'b0;
    ref_mem[32'h40] = 8'h44;
    @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus.ram_addr_o !== 32'd0 || bus.ram_wr_o !== 1'b0 || bus.mem_done_o || bus.if_done_o) ok = 1'b0;
    end
    checkOutput("rstmid_stays_idle", {31'd0, ok}, 32'd1);
    modelTxn(1'b1, 1'b0, 2'b10, 32'h40, 32'h0, exp_rd, exp_lat);
    applyStimulus(1'b1, 1'b0, 2'b10, 32'h40, 32'h0, got, lat, ok);
    checkOutput("rstmid_partial_rdata", got, 32'h00000044);
    checkOutput("rstmid_latency", lat, 6);
    checkOutput("rstmid_trace", {31'd0, ok}, 32'd1);

    // Random transactions against the reference memory
    for (int r = 0; r < 40; r++) begin
      bit          rm, rw;
      logic [1:0]  rl;
      logic [31:0] ra, rwd;
      rm  = ($urandom % 4) != 0;
      rw  = rm && ($urandom % 2 == 1);
      rl  = 2'($urandom % 4);
      ra  = 32'h200 + $urandom_range(0, 15);
      rwd = $urandom;
      modelTxn(rm, rw, rl, ra, rwd, exp_rd, exp_lat);
      applyStimulus(rm, rw, rl, ra, rwd, got, lat, ok2);
      checkOutput($sformatf("rand%0d_rdata", r), got, exp_rd);
      checkOutput($sformatf("rand%0d_latency", r), lat, exp_lat);
      checkOutput($sformatf("rand%0d_trace", r), {31'd0, ok2}, 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
